// File: rtl/multi_channel_sampler.sv
// rtl/multi_channel_sampler.sv - gated multi-channel ADC capture buffer with interleaved word replay
module multi_channel_sampler #(
    parameter int DATA_SIZE    = 8,
    parameter int NUM_CHANNELS = 2,
    parameter int DEPTH        = 256,
    parameter int PARAM_SIZE   = 4
) (
    input  logic                                 i_clock,
    input  logic                                 i_reset,
    input  logic [NUM_CHANNELS*DATA_SIZE-1:0]    i_data,
    input  logic                                 i_adc_init,
    input  logic                                 i_gate,
    input  logic                                 i_sample,
    input  logic                                 i_cmd_decim,
    input  logic [PARAM_SIZE-1:0]                i_cmd_param,
    input  logic                                 i_next,
    output logic [DATA_SIZE-1:0]                 o_data,
    output logic                                 o_valid,
    output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] o_channel,
    output logic                                 o_idle
);

    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int AW   = $clog2(DEPTH);
    localparam int WW   = NUM_CHANNELS * DATA_SIZE;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);
    localparam logic [AW:0]     FULL_M1 = (AW + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_FETCH,
        S_LOAD,
        S_SHOW
    } state_t;

    state_t state, state_next;

    logic            gate_meta, gate_sync, gate_prev, gate_rise, gate_fall;
    logic [PARAM_SIZE-1:0] decim, decim_cnt;
    logic [AW:0]     n_stored;
    logic [AW-1:0]   rd_sample, rd_addr;
    logic [CH_W-1:0] rd_ch;
    logic            wr_en, rd_en, load_word, xfer, start_capture, last_word;

    logic [WW-1:0]        mem [DEPTH];
    logic [WW-1:0]        rd_word;
    logic [DATA_SIZE-1:0] rd_lanes [NUM_CHANNELS];

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
        assign rd_lanes[c] = rd_word[c*DATA_SIZE +: DATA_SIZE];
    end

    // Two-stage synchroniser followed by a registered edge detector.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            gate_meta <= 1'b0;
            gate_sync <= 1'b0;
            gate_prev <= 1'b0;
            gate_rise <= 1'b0;
            gate_fall <= 1'b0;
        end else begin
            gate_meta <= i_gate;
            gate_sync <= gate_meta;
            gate_prev <= gate_sync;
            gate_rise <= gate_sync & ~gate_prev;
            gate_fall <= ~gate_sync & gate_prev;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) state <= S_IDLE;
        else          state <= state_next;
    end

    assign last_word = ({1'b0, rd_sample} == n_stored - 1'b1) && (rd_ch == LAST_CH);

    always_comb begin
        state_next    = state;
        wr_en         = 1'b0;
        rd_en         = 1'b0;
        rd_addr       = rd_sample;
        load_word     = 1'b0;
        xfer          = 1'b0;
        start_capture = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_sample && i_adc_init) state_next = S_ARMED;
            end
            S_ARMED: begin
                if (gate_rise) begin
                    start_capture = 1'b1;
                    state_next    = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                wr_en = (decim_cnt == decim);
                if (gate_fall || (wr_en && n_stored == FULL_M1)) state_next = S_FETCH;
            end
            S_FETCH: begin
                rd_en      = 1'b1;
                state_next = S_LOAD;
            end
            S_LOAD: begin
                load_word  = 1'b1;
                state_next = S_SHOW;
            end
            S_SHOW: begin
                if (i_next) begin
                    xfer = 1'b1;
                    if (last_word) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_LOAD;
                        // Prefetch the next sample now so the gap stays one cycle.
                        if (rd_ch == LAST_CH) begin
                            rd_en   = 1'b1;
                            rd_addr = rd_sample + 1'b1;
                        end
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (wr_en && i_reset) mem[n_stored[AW-1:0]] <= i_data;
        if (rd_en)            rd_word <= mem[rd_addr];
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            decim     <= '0;
            decim_cnt <= '0;
            n_stored  <= '0;
            rd_sample <= '0;
            rd_ch     <= '0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_channel <= '0;
        end else begin
            if (state == S_IDLE && i_cmd_decim) decim <= i_cmd_param;
            if (start_capture) begin
                decim_cnt <= decim;
                n_stored  <= '0;
                rd_sample <= '0;
                rd_ch     <= '0;
            end else if (state == S_CAPTURE) begin
                if (wr_en) begin
                    decim_cnt <= '0;
                    n_stored  <= n_stored + 1'b1;
                end else begin
                    decim_cnt <= decim_cnt + 1'b1;
                end
            end
            if (load_word) begin
                o_data    <= rd_lanes[rd_ch];
                o_channel <= rd_ch;
                o_valid   <= 1'b1;
            end
            if (xfer) begin
                o_valid <= 1'b0;
                if (rd_ch == LAST_CH) begin
                    rd_ch     <= '0;
                    rd_sample <= rd_sample + 1'b1;
                end else begin
                    rd_ch <= rd_ch + 1'b1;
                end
            end
        end
    end

    assign o_idle = (state == S_IDLE);

endmodule

// File: tb/tb_multi_channel_sampler.sv
// tb/tb_multi_channel_sampler.sv - randomized self-checking bench for multi_channel_sampler
module tb_multi_channel_sampler;

    localparam int DW    = 8;
    localparam int NC    = 2;
    localparam int DEPTH = 8;
    localparam int PS    = 4;

    logic            clk = 1'b0;
    logic            i_reset, i_adc_init, i_gate, i_sample, i_cmd_decim, i_next;
    logic [NC*DW-1:0] i_data;
    logic [PS-1:0]   i_cmd_param;
    logic [DW-1:0]   o_data;
    logic            o_valid, o_idle;
    logic [0:0]      o_channel;

    int vectors     = 0;
    int miscompares = 0;
    int pe          = 0;
    int kcnt        = 0;
    int cur_d       = 0;
    bit rand_data   = 1'b0;

    logic [NC*DW-1:0] hist [int];

    typedef struct {
        int s;
        int c;
    } exp_t;

    always #5 clk = ~clk;
    always @(posedge clk) pe++;

    multi_channel_sampler #(
        .DATA_SIZE   (DW),
        .NUM_CHANNELS(NC),
        .DEPTH       (DEPTH),
        .PARAM_SIZE  (PS)
    ) dut (
        .i_clock    (clk),
        .i_reset    (i_reset),
        .i_data     (i_data),
        .i_adc_init (i_adc_init),
        .i_gate     (i_gate),
        .i_sample   (i_sample),
        .i_cmd_decim(i_cmd_decim),
        .i_cmd_param(i_cmd_param),
        .i_next     (i_next),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_channel  (o_channel),
        .o_idle     (o_idle)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Advance to the next falling edge and present the word sampled at posedge number pe.
    task automatic step();
        @(negedge clk);
        i_data = rand_data ? (NC*DW)'($urandom) : {8'(kcnt + 128), 8'(kcnt)};
        hist[pe] = i_data;
        kcnt++;
    endtask

    task automatic run_capture(input int d, input int gate_len, input int bp,
                               input int abort_after, input bit reload);
        exp_t eq[$];
        exp_t e;
        int r, f, x, n, s, xfers, since, hold, budget;
        bit seen;
        logic pv, pn;
        logic [DW-1:0] pd;
        logic [0:0] pc;
        logic [NC*DW-1:0] w;

        i_gate = 1'b0;
        i_next = 1'b0;
        for (int i = 0; i < 4; i++) step();
        if (d >= 0) begin
            i_cmd_decim = 1'b1;
            i_cmd_param = PS'(d);
            step();
            i_cmd_decim = 1'b0;
            cur_d = d;
        end
        i_sample = 1'b1;
        i_adc_init = 1'b1;
        step();
        i_sample = 1'b0;
        step();
        step();
        check("armed_not_idle", o_idle, 0);

        i_gate = 1'b1;
        r = pe;
        f = r + gate_len;
        n = 0;
        x = 0;
        // Writes land on the first capture edge (rise + 4) and every D+1 edges after,
        // up to and including the edge where the fall is seen (fall + 3), at most DEPTH.
        for (int j = 0; j < DEPTH; j++) begin
            s = r + 4 + j * (cur_d + 1);
            if (s > f + 3) break;
            for (int c = 0; c < NC; c++) eq.push_back('{s, c});
            n++;
            x = s;
        end
        if (n != DEPTH) x = f + 3;

        xfers = 0; since = 99; hold = 0; seen = 1'b0; budget = 0;
        pv = 1'b0; pn = 1'b0; pd = '0; pc = '0;
        while ((eq.size() > 0 || pe <= f + 4) && budget < 400 &&
               !(abort_after > 0 && xfers == abort_after)) begin
            budget++;
            if (pe == f) i_gate = 1'b0;
            i_cmd_decim = reload && (pe == r + 6);
            i_cmd_param = PS'(cur_d + 2);
            since++;
            if (o_valid && !seen) begin
                seen = 1'b1;
                check("first_valid_cycle", pe, x + 3);
            end
            if (since == 1) check("gap_low", o_valid, 0);
            if (since == 2 && eq.size() > 0) check("gap_next", o_valid, 1);
            if (pv && !pn) check("hold", {o_valid, o_channel, o_data}, {1'b1, pc, pd});
            if (o_valid && xfers == 0) hold++;
            case (bp)
                0:       i_next = 1'b1;
                1:       i_next = 1'($urandom_range(0, 1));
                default: i_next = (xfers > 0 || hold > 5);
            endcase
            if (o_valid && i_next) begin
                if (eq.size() == 0) begin
                    check("word_count", xfers + 1, n * NC);
                end else begin
                    e = eq.pop_front();
                    w = hist[e.s];
                    check("data", o_data, w[e.c*DW +: DW]);
                    check("channel", o_channel, e.c);
                end
                xfers++;
                since = 0;
            end
            pv = o_valid; pn = i_next; pd = o_data; pc = o_channel;
            step();
        end
        i_cmd_decim = 1'b0;
        i_next = 1'b0;

        if (abort_after > 0) begin
            check("abort_xfers", xfers, abort_after);
            i_reset = 1'b0;
            step();
            i_reset = 1'b1;
            check("abort_idle", o_idle, 1);
            check("abort_valid", o_valid, 0);
            check("abort_data", o_data, 0);
            check("abort_chan", o_channel, 0);
            cur_d = 0;
        end else begin
            check("all_words", eq.size(), 0);
            check("end_valid_low", o_valid, 0);
            check("end_idle", o_idle, 1);
        end
    endtask

    initial begin
        i_reset = 1'b0; i_adc_init = 1'b0; i_gate = 1'b0; i_sample = 1'b0;
        i_cmd_decim = 1'b0; i_cmd_param = '0; i_next = 1'b0; i_data = '0;

        for (int i = 0; i < 3; i++) begin
            i_gate      = 1'($urandom_range(0, 1));
            i_sample    = 1'($urandom_range(0, 1));
            i_adc_init  = 1'($urandom_range(0, 1));
            i_cmd_decim = 1'($urandom_range(0, 1));
            i_cmd_param = PS'($urandom);
            i_next      = 1'($urandom_range(0, 1));
            step();
        end
        check("reset_valid", o_valid, 0);
        check("reset_data", o_data, 0);
        check("reset_chan", o_channel, 0);
        check("reset_idle", o_idle, 1);

        i_reset = 1'b1;
        i_gate = 1'b0; i_sample = 1'b0; i_adc_init = 1'b0; i_cmd_decim = 1'b0; i_next = 1'b0;
        for (int i = 0; i < 4; i++) step();
        i_sample = 1'b1;
        step();
        i_sample = 1'b0;
        step();
        check("sample_without_init", o_idle, 1);

        rand_data = 1'b0;
        run_capture(0, 40, 0, 0, 1'b0);
        run_capture(3, 40, 1, 0, 1'b1);

        rand_data = 1'b1;
        run_capture(0, 3, 1, 0, 1'b0);
        run_capture(0, 40, 2, 0, 1'b0);
        run_capture(2, 40, 0, 3, 1'b0);
        run_capture(-1, 5, 1, 0, 1'b0);
        for (int i = 0; i < 4; i++)
            run_capture(int'($urandom_range(0, 3)), int'($urandom_range(1, 20)), 1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_channel_sampler.md
Name: multi_channel_sampler

Overview:
- Parametrised successor to the single-channel sampler.
- Captures NUM_CHANNELS parallel ADC words into an internal buffer of DEPTH entries while the external gate is high, with optional decimation.
- Replays the capture as a channel-interleaved word stream over a valid/next handshake, toward uart_tx or any ready/valid sink.
- Sits between the ADC front end and the serial link.

Parameters:
- DATA_SIZE, 8, width of one channel word and of o_data.
- NUM_CHANNELS, 2, number of channels packed in i_data (>=1).
- DEPTH, 256, sample slots per channel (power of two, >=2).
- PARAM_SIZE, 4, width of the decimation command parameter.

Ports:
- i_clock  in  1  sole clock, rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_data  in  NUM_CHANNELS*DATA_SIZE  channel c at bits [c*DATA_SIZE +: DATA_SIZE].
- i_adc_init  in  1  ADC ready; arming is blocked while low.
- i_gate  in  1  asynchronous capture window; synchronised internally.
- i_sample  in  1  one-cycle arm request.
- i_cmd_decim  in  1  load decimation parameter.
- i_cmd_param  in  PARAM_SIZE  decimation value D; capture every D+1 cycles.
- i_next  in  1  sink ready; a transfer occurs when o_valid and i_next are both high at a rising edge.
- o_data  out  DATA_SIZE  current output word.
- o_valid  out  1  o_data valid.
- o_channel  out  max(1,clog2(NUM_CHANNELS))  channel index of o_data.
- o_idle  out  1  high only in IDLE.

Behaviour:
- Reset (i_reset low at a rising edge):
  - state IDLE; o_valid=0, o_data=0, o_channel=0, o_idle=1.
  - decimation register D=0; write address, sample count and read pointers cleared.
  - Reset wins over every other input and aborts any operation in progress.
  - Buffer contents are undefined after reset; nothing stale is ever emitted.
- Gate path:
  - i_gate passes through a 2-FF synchroniser, then a registered edge detector.
  - A rise/fall edge is seen internally 3 cycles after the input transition.
- Decimation:
  - D loads from i_cmd_param when i_cmd_decim is high in IDLE.
  - i_cmd_decim is ignored in every other state; D persists until reset or the next load.
- IDLE:
  - i_sample=1 and i_adc_init=1 at the same edge -> ARMED.
  - i_sample with i_adc_init=0 is ignored.
- ARMED:
  - Synchronised gate rising edge -> CAPTURE; write address=0, decimation counter=D.
  - A gate already high at arming does not trigger; a fresh rising edge is required.
- CAPTURE:
  - Decimation counter==D at an edge: write all channels of i_data, as sampled at that edge, to slot wr_addr; wr_addr+1; counter=0.
  - Otherwise counter+1.
  - The first write therefore occurs on the first CAPTURE cycle, then every D+1 cycles.
  - Ends on the synchronised gate falling edge or when DEPTH samples are written, whichever comes first -> DUMP.
  - Stored count N is 1..DEPTH.
  - If a write and the gate fall coincide, the write is kept.
  - The buffer never wraps; capture stops when full.
- DUMP:
  - Emits N*NUM_CHANNELS words in order sample0 ch0..chC-1, sample1 ch0.., and so on.
  - Buffer is synchronous-read: o_valid rises 2 cycles after DUMP entry.
  - o_data and o_channel are held stable while o_valid=1 and i_next=0.
  - After each transfer, o_valid is low for exactly one cycle, then the next word is presented.
  - After the last transfer: o_valid=0, state -> IDLE.
- i_sample and gate activity in CAPTURE or DUMP are ignored.
- i_next while o_valid=0 has no effect.
- NUM_CHANNELS=1 degenerates to the single-channel sampler with o_channel tied 0.

Test Plan:
- Reset: hold i_reset=0 for 3 cycles with random inputs -> o_valid=0, o_data=0, o_channel=0, o_idle=1; i_sample with i_adc_init=0 -> o_idle stays 1.
- Full capture (NUM_CHANNELS=2, DEPTH=8, D=0):
  - Stimulus: ch0=k, ch1=k+128 on a free-running per-clock counter k; arm; gate high 40 cycles.
  - Required: 16 words v,v+128,v+1,v+129,...,v+7,v+135, where v is k at the first CAPTURE edge.
  - o_channel alternates 0,1; o_idle returns to 1.
- Decimation: load D=3 in IDLE, then repeat the full-capture case -> ch0 words are v,v+4,v+8,...,v+28.
  - A second load attempted during CAPTURE does not change the spacing.
- Early gate fall (DEPTH=8, D=0): gate high long enough for 3 writes -> exactly 6 words emitted, then IDLE.
- Backpressure: hold i_next=0 for 5 cycles with o_valid=1 -> o_data and o_channel unchanged.
  - Then pulse i_next for 1 cycle -> o_valid low 1 cycle, next word follows; no word lost or duplicated.
- Reset mid-DUMP after 3 transfers -> next cycle idle with o_valid=0.
  - A new arm/capture returns only fresh data, starting at sample 0.
